// File: rtl/mcu_serial_pkg.sv
// Shared definitions for the MCU serial transmit path: FSM state codes,
// default timing constants and frame geometry.
package mcu_serial_pkg;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t ST_IDLE  = 2'd0;
  localparam tx_state_t ST_START = 2'd1;
  localparam tx_state_t ST_DATA  = 2'd2;
  localparam tx_state_t ST_STOP  = 2'd3;

  localparam int DEF_CLK_PER_BIT = 100;
  localparam int DEF_CCLK_STABLE = 512;
  localparam int FRAME_BITS      = 10;
  localparam int DATA_BITS       = 8;

endpackage

// File: rtl/mcu_serial_tx_fifo.sv
// Single-clock byte FIFO, first-word-fall-through, with registered count/full/empty.
// A push while full is accepted only when a pop happens on the same edge.
import mcu_serial_pkg::*;

module sync_fifo #(
  parameter int AW = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_BITS-1:0]  wr_data,
  input  logic                  rd_en,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic [AW:0]           count,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_wr;
  logic                 do_rd;
  logic [AW:0]          count_nxt;

  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/mcu_serial_tx.sv
// UART transmitter toward the Mojo MCU: FIFO-buffered bytes, sent 8N1 once the
// MCU is ready (cclk stable high) and not applying tx_block back-pressure.
import mcu_serial_pkg::*;

module mcu_serial_tx #(
  parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
  parameter int FIFO_AW     = 3,
  parameter int CCLK_STABLE = DEF_CCLK_STABLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cclk,
  input  logic                 tx_block,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 new_tx_data,
  output logic                 tx,
  output logic                 fifo_full,
  output logic [FIFO_AW:0]     fifo_count,
  output logic                 overflow,
  output logic                 busy
);

  localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int RW = $clog2(CCLK_STABLE + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLK_PER_BIT - 1);
  localparam logic [RW-1:0] RDY_MAX  = RW'(CCLK_STABLE);

  (* ASYNC_REG = "TRUE" *) logic cclk_m;
  (* ASYNC_REG = "TRUE" *) logic cclk_s;
  (* ASYNC_REG = "TRUE" *) logic tx_block_m;
  (* ASYNC_REG = "TRUE" *) logic tx_block_s;

  logic [RW-1:0]        rdy_cnt;
  logic                 ready;
  tx_state_t            state;
  logic [BW-1:0]        bit_cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] head;
  logic                 tx_q;
  logic                 fifo_empty;
  logic                 pop;
  logic                 bit_end;

  sync_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (new_tx_data),
    .wr_data (tx_data),
    .rd_en   (pop),
    .rd_data (head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign ready   = (rdy_cnt == RDY_MAX);
  assign pop     = (state == ST_IDLE) && ready && !tx_block_s && !fifo_empty;
  assign bit_end = (bit_cnt == BIT_LAST);
  assign tx      = tx_q;
  assign busy    = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cclk_m     <= 1'b0;
      cclk_s     <= 1'b0;
      tx_block_m <= 1'b0;
      tx_block_s <= 1'b0;
    end else begin
      cclk_m     <= cclk;
      cclk_s     <= cclk_m;
      tx_block_m <= tx_block;
      tx_block_s <= tx_block_m;
    end
  end

  // Readiness: cclk must stay high for CCLK_STABLE consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_cnt <= '0;
    end else if (!cclk_s) begin
      rdy_cnt <= '0;
    end else if (rdy_cnt != RDY_MAX) begin
      rdy_cnt <= rdy_cnt + 1'b1;
    end
  end

  // A dropped write is one that finds the FIFO full with no pop freeing a slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (new_tx_data && fifo_full && !pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= head;
    end else if (state == ST_DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pop) begin
            state   <= ST_START;
            bit_cnt <= '0;
            tx_q    <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx_q    <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_q    <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_serial_tx.sv
// Randomised and directed bench for mcu_serial_tx against a frame-level
// behavioural model, plus a line decoder for end-to-end byte checks.
module tb_mcu_serial_tx;

  localparam int CPB    = 100;
  localparam int AW     = 3;
  localparam int STABLE = 512;
  localparam int DEPTH  = 8;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cclk = 1'b1;
  logic       tx_block = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       new_tx_data = 1'b0;
  logic       tx;
  logic       fifo_full;
  logic [AW:0] fifo_count;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // behavioural model state
  bit         m_cs1 = 0, m_cs2 = 0, m_tb1 = 0, m_tb2 = 0;
  bit         m_active = 0, m_ovf = 0;
  int         m_run = 0, m_el = 0;
  logic [7:0] m_cur = 8'h00;
  logic [7:0] m_q[$];
  logic [7:0] m_sent[$];

  logic [7:0] got[$];
  int         starts[$];
  bit         prev_busy = 0;

  mcu_serial_tx #(.CLK_PER_BIT(CPB), .FIFO_AW(AW), .CCLK_STABLE(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .cclk        (cclk),
    .tx_block    (tx_block),
    .tx_data     (tx_data),
    .new_tx_data (new_tx_data),
    .tx          (tx),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_el / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_cur[idx-1];
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_cs1 = 0; m_cs2 = 0; m_tb1 = 0; m_tb2 = 0;
    m_run = 0; m_active = 0; m_el = 0; m_ovf = 0;
    m_q.delete();
  endtask

  // One clock edge of the spec: decisions use the values held before the edge.
  task automatic model_step();
    bit rdy;
    rdy = (m_run == STABLE);
    if (m_active) begin
      m_el++;
      if (m_el == 10 * CPB) begin
        m_active = 0;
        m_sent.push_back(m_cur);
      end
    end else if (rdy && !m_tb2 && m_q.size() != 0) begin
      m_cur    = m_q.pop_front();
      m_active = 1;
      m_el     = 0;
    end
    if (new_tx_data) begin
      if (m_q.size() < DEPTH) m_q.push_back(tx_data);
      else m_ovf = 1;
    end
    if (m_cs2) begin
      if (m_run < STABLE) m_run++;
    end else begin
      m_run = 0;
    end
    m_cs2 = m_cs1; m_cs1 = cclk;
    m_tb2 = m_tb1; m_tb1 = tx_block;
  endtask

  // model update and per-cycle compare
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) model_reset();
    else model_step();
    #1;
    chk("tx", tx, exp_tx());
    chk("busy", busy, m_active);
    chk("fifo_count", fifo_count, m_q.size());
    chk("fifo_full", fifo_full, m_q.size() == DEPTH);
    chk("overflow", overflow, m_ovf);
    if (!prev_busy && busy) starts.push_back(cyc);
    prev_busy = rst ? busy : 1'b0;
  end

  // line decoder: samples the middle of each bit after a start is seen
  initial begin
    bit         dbusy;
    int         dcnt;
    logic [7:0] dbyte;
    dbusy = 0; dcnt = 0; dbyte = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        dbusy = 0;
      end else if (!dbusy) begin
        if (tx == 1'b0) begin dbusy = 1; dcnt = 0; end
      end else begin
        dcnt++;
        for (int k = 1; k <= 8; k++)
          if (dcnt == k * CPB + CPB / 2) dbyte[k-1] = tx;
        if (dcnt == 9 * CPB + CPB / 2) begin
          got.push_back(dbyte);
          dbusy = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    tx_data = b;
    new_tx_data = 1'b1;
    @(negedge clk);
    new_tx_data = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int bound);
    for (int i = 0; i < bound && starts.size() < n; i++) @(negedge clk);
    chk("start_seen", starts.size() >= n, 1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && (busy || fifo_count != 0); i++) @(negedge clk);
    chk("drained", busy || fifo_count != 0, 0);
  endtask

  task automatic wait_not_busy(input int bound);
    for (int i = 0; i < bound && busy; i++) @(negedge clk);
    chk("frame_end", busy, 0);
  endtask

  task automatic chk_frames(input string name, input int g0, input byte_q_t exp);
    chk({name, "_n"}, got.size() - g0, exp.size());
    for (int i = 0; i < exp.size(); i++)
      if (g0 + i < got.size()) chk(name, got[g0+i], exp[i]);
  endtask

  initial begin
    int r, n0, g0, rc, cdrop;
    logic [9:0] pat;
    byte_q_t e;

    // reset values
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_count", fifo_count, 0);
    chk("rst_full", fifo_full, 0); chk("rst_ovf", overflow, 0);

    // readiness gate
    rst = 1'b1; r = cyc; g0 = got.size(); n0 = starts.size();
    repeat (10) @(negedge clk);
    push(8'h55);
    repeat (480) @(negedge clk);
    chk("gate_tx", tx, 1); chk("gate_busy", busy, 0); chk("gate_count", fifo_count, 1);
    wait_starts(n0 + 1, 200);
    if (starts.size() > n0) chk_rng("ready_delay", starts[n0] - r, 512, 520);
    pat = 10'b1_01010101_0;
    for (int k = 0; k < 10; k++) begin
      repeat (k == 0 ? 50 : 100) @(negedge clk);
      chk("bit55", tx, pat[k]);
    end
    wait_idle(1000);
    e = '{8'h55}; chk_frames("byte55", g0, e);

    // burst and overflow
    g0 = got.size();
    for (int i = 1; i <= 9; i++) push(8'(i));
    repeat (200) @(negedge clk);
    for (int i = 10; i <= 18; i++) push(8'(i));
    chk("burst_full", fifo_full, 1); chk("burst_ovf", overflow, 1); chk("burst_count", fifo_count, 8);
    wait_idle(12000);
    e = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    chk_frames("burst", g0, e);

    // back-pressure
    g0 = got.size(); n0 = starts.size();
    tx_block = 1'b1;
    repeat (5) @(negedge clk);
    push(8'h31); push(8'h32); push(8'h33);
    repeat (50) @(negedge clk);
    chk("bp_count", fifo_count, 3); chk("bp_busy", busy, 0);
    tx_block = 1'b0;
    wait_starts(n0 + 2, 3000);
    if (starts.size() >= n0 + 2) chk("bp_gap", starts[n0+1] - starts[n0], 1001);
    repeat (300) @(negedge clk);
    tx_block = 1'b1;
    wait_not_busy(1500);
    repeat (200) @(negedge clk);
    chk("bp_hold_busy", busy, 0); chk("bp_hold_count", fifo_count, 1);
    chk("bp_hold_tx", tx, 1); chk("bp_hold_starts", starts.size() - n0, 2);
    tx_block = 1'b0;
    wait_idle(2000);
    e = '{8'h31, 8'h32, 8'h33}; chk_frames("bp", g0, e);

    // cclk drop near the end of a frame
    g0 = got.size(); n0 = starts.size();
    push(8'h41); push(8'h42);
    wait_starts(n0 + 1, 100);
    repeat (900) @(negedge clk);
    cclk = 1'b0;
    repeat (50) @(negedge clk);
    cclk = 1'b1; rc = cyc;
    repeat (300) @(negedge clk);
    chk("cdrop_busy", busy, 0); chk("cdrop_count", fifo_count, 1);
    wait_starts(n0 + 2, 1000);
    if (starts.size() >= n0 + 2) chk_rng("cdrop_delay", starts[n0+1] - rc, 512, 520);
    wait_idle(2000);
    e = '{8'h41, 8'h42}; chk_frames("cdrop", g0, e);

    // asynchronous reset in DATA bit 4
    n0 = starts.size();
    push(8'h66); push(8'h77);
    wait_starts(n0 + 1, 100);
    repeat (550) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_tx", tx, 1); chk("arst_busy", busy, 0); chk("arst_count", fifo_count, 0);
    chk("arst_full", fifo_full, 0); chk("arst_ovf", overflow, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1; g0 = got.size(); n0 = starts.size();
    repeat (2000) @(negedge clk);
    chk("arst_nothing", got.size() - g0, 0); chk("arst_nostart", starts.size() - n0, 0);

    // push coinciding with the pop from a full FIFO
    g0 = got.size();
    tx_block = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
    chk("pp_full", fifo_full, 1); chk("pp_count", fifo_count, 8);
    tx_block = 1'b0;
    @(negedge clk); @(negedge clk);
    push(8'hA5);
    chk("pp_count_after", fifo_count, 8); chk("pp_ovf", overflow, 0); chk("pp_busy", busy, 1);
    wait_idle(12000);
    e = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hA5};
    chk_frames("pp", g0, e);

    // randomised traffic
    cdrop = 0;
    for (int i = 0; i < 15000; i++) begin
      tx_data = 8'($urandom);
      new_tx_data = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 999) < 2) tx_block = ~tx_block;
      if (cdrop > 0) begin
        cdrop--;
        if (cdrop == 0) cclk = 1'b1;
      end else if ($urandom_range(0, 1999) == 0) begin
        cclk = 1'b0;
        cdrop = $urandom_range(1, 20);
      end
      @(negedge clk);
    end
    new_tx_data = 1'b0; tx_block = 1'b0; cclk = 1'b1;
    wait_idle(12000);

    // every completed frame on the line matches the model's sent list
    chk("sent_n", got.size(), m_sent.size());
    for (int i = 0; i < got.size() && i < m_sent.size(); i++) chk("sent_byte", got[i], m_sent[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
